// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: main/side street light controller with car-sensor extension and pedestrian walk phase
module traffic_light_sequencer (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       tick_1hz,
  input  logic       sensor_sync,
  input  logic       walk_request,
  input  logic       prog_sync,
  input  logic [3:0] value,
  output logic [1:0] time_selector,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk,
  output logic [2:0] state_id,
  output logic       expired
);
  typedef enum logic [2:0] {
    MG_BASE = 3'd0,
    MG_EXT  = 3'd1,
    MY      = 3'd2,
    WALK    = 3'd3,
    SG      = 3'd4,
    SG_EXT  = 3'd5,
    SY      = 3'd6
  } state_t;
  state_t     r_state, w_next;
  logic [3:0] r_remaining;
  logic       r_load_pending, r_car_pending, r_walk_pending, w_enter;
  function automatic logic [2:0] main_of(input state_t s);
    return (s == MG_BASE || s == MG_EXT) ? 3'b001 : (s == MY) ? 3'b010 : 3'b100;
  endfunction
  function automatic logic [2:0] side_of(input state_t s);
    return (s == SG || s == SG_EXT) ? 3'b001 : (s == SY) ? 3'b010 : 3'b100;
  endfunction
  function automatic logic [1:0] sel_of(input state_t s);
    return (s == MY || s == SY) ? 2'b10 : (s == MG_EXT || s == WALK || s == SG_EXT) ? 2'b01 : 2'b00;
  endfunction
  assign state_id = r_state;
  // Ticks are ignored while a load is pending, so a state always runs max(value,1) ticks
  assign expired  = tick_1hz & ~r_load_pending & (r_remaining == 4'd1);
  assign w_enter  = prog_sync | expired;
  always_comb begin
    w_next = MG_BASE;
    if (!prog_sync)
      case (r_state)
        MG_BASE: w_next = (r_car_pending | sensor_sync) ? MG_EXT : MG_BASE;
        MG_EXT:  w_next = MY;
        MY:      w_next = r_walk_pending ? WALK : SG;
        WALK:    w_next = SG;
        SG:      w_next = sensor_sync ? SG_EXT : SY;
        SG_EXT:  w_next = SY;
        default: w_next = MG_BASE;
      endcase
  end
  always_ff @(posedge clk or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      r_state        <= MG_BASE;
      time_selector  <= 2'b00;
      main_lights    <= 3'b001;
      side_lights    <= 3'b100;
      walk           <= 1'b0;
      r_remaining    <= 4'd0;
      r_load_pending <= 1'b1;
      r_car_pending  <= 1'b0;
      r_walk_pending <= 1'b0;
    end else begin
      r_car_pending  <= (prog_sync || (w_enter && w_next == MY)) ? 1'b0 : (r_car_pending | sensor_sync);
      r_walk_pending <= (prog_sync || (w_enter && w_next == WALK)) ? 1'b0 : (r_walk_pending | walk_request);
      if (w_enter) begin
        r_state        <= w_next;
        r_load_pending <= 1'b1;
        time_selector  <= sel_of(w_next);
        main_lights    <= main_of(w_next);
        side_lights    <= side_of(w_next);
        walk           <= (w_next == WALK);
      end else if (r_load_pending) begin
        r_remaining    <= (value == 4'd0) ? 4'd1 : value;
        r_load_pending <= 1'b0;
      end else if (tick_1hz) begin
        r_remaining    <= r_remaining - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb_traffic_light_sequencer: table-driven per-state residence checks plus program and async-reset sequences
module tb_traffic_light_sequencer;
  logic       clk = 1'b0;
  logic       Reset_Sync, tick_1hz, sensor_sync, walk_request, prog_sync;
  logic [3:0] value, t_base;
  logic [1:0] time_selector;
  logic [2:0] main_lights, side_lights, state_id;
  logic       walk, expired;
  int         checks = 0, errors = 0;
  typedef struct {
    logic [11:0] outs;
    int          len;
    logic        sen_first, wreq_first, sen_hold, sen_last;
    int          new_base;
  } row_t;
  localparam logic [11:0] O_MGB = {3'd0, 2'b00, 3'b001, 3'b100, 1'b0};
  localparam logic [11:0] O_MGE = {3'd1, 2'b01, 3'b001, 3'b100, 1'b0};
  localparam logic [11:0] O_MY  = {3'd2, 2'b10, 3'b010, 3'b100, 1'b0};
  localparam logic [11:0] O_WLK = {3'd3, 2'b01, 3'b100, 3'b100, 1'b1};
  localparam logic [11:0] O_SG  = {3'd4, 2'b00, 3'b100, 3'b001, 1'b0};
  localparam logic [11:0] O_SGE = {3'd5, 2'b01, 3'b100, 3'b001, 1'b0};
  localparam logic [11:0] O_SY  = {3'd6, 2'b10, 3'b100, 3'b010, 1'b0};
  row_t rows[14];
  always #5 clk = ~clk;
  // Time-parameter store: tEXT=3, tYEL=2, tBASE adjustable for the value=0 cases
  assign value = (time_selector == 2'b00) ? t_base : (time_selector == 2'b01) ? 4'd3 : 4'd2;
  traffic_light_sequencer dut (
    .clk(clk), .Reset_Sync(Reset_Sync), .tick_1hz(tick_1hz), .sensor_sync(sensor_sync),
    .walk_request(walk_request), .prog_sync(prog_sync), .value(value),
    .time_selector(time_selector), .main_lights(main_lights), .side_lights(side_lights),
    .walk(walk), .state_id(state_id), .expired(expired)
  );
  function automatic row_t mk(input logic [11:0] o, input int n, input logic sf = 0, input logic wf = 0,
                              input logic sh = 0, input logic sl = 0, input int nb = -1);
    row_t r;
    r.outs = o; r.len = n; r.sen_first = sf; r.wreq_first = wf; r.sen_hold = sh; r.sen_last = sl; r.new_base = nb;
    return r;
  endfunction
  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {state_id, time_selector, main_lights, side_lights, walk, expired};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {st,sel,main,side,walk,exp}=%b required %b", name, act, exp);
    end
  endtask
  task automatic run_row(input row_t r);
    for (int c = 0; c <= r.len; c++) begin
      sensor_sync  = r.sen_hold | (c == 0 && r.sen_first) | (c == r.len && r.sen_last);
      walk_request = (c == 0) && r.wreq_first;
      prog_sync    = 1'b0;
      if (c == 1 && r.new_base >= 0) t_base = 4'(r.new_base);
      #1 check($sformatf("state%0d_cycle%0d", r.outs[11:9], c), {r.outs, 1'(c == r.len)});
      @(negedge clk);
    end
  endtask
  initial begin
    rows[0]  = mk(O_MGB, 6);
    rows[1]  = mk(O_MGB, 6, 1);
    rows[2]  = mk(O_MGE, 3, 0, 1);
    rows[3]  = mk(O_MY,  2);
    rows[4]  = mk(O_WLK, 3);
    rows[5]  = mk(O_SG,  6, 0, 0, 1);
    rows[6]  = mk(O_SGE, 3);
    rows[7]  = mk(O_SY,  2);
    rows[8]  = mk(O_MGB, 6);
    rows[9]  = mk(O_MGE, 3);
    rows[10] = mk(O_MY,  2);
    rows[11] = mk(O_SG,  6);
    rows[12] = mk(O_SY,  2);
    rows[13] = mk(O_MGB, 6);
    t_base = 4'd6; tick_1hz = 1'b1;
    sensor_sync = 1'b0; walk_request = 1'b0; prog_sync = 1'b0;
    Reset_Sync = 1'b1;
    @(negedge clk);
    #1 check("reset", {O_MGB, 1'b0});
    Reset_Sync = 1'b0;
    foreach (rows[i]) run_row(rows[i]);
    run_row(mk(O_MGB, 6, 1));
    run_row(mk(O_MGE, 3));
    run_row(mk(O_MY, 2));
    for (int c = 0; c <= 2; c++) begin
      sensor_sync = (c == 2); walk_request = (c == 2); prog_sync = (c == 2);
      #1 check($sformatf("prog_sg_cycle%0d", c), {O_SG, 1'b0});
      @(negedge clk);
    end
    run_row(mk(O_MGB, 6));
    run_row(mk(O_MGB, 6, 0, 0, 0, 1));
    run_row(mk(O_MGE, 3));
    run_row(mk(O_MY, 2));
    t_base = 4'd0;
    run_row(mk(O_SG, 1));
    run_row(mk(O_SY, 2));
    run_row(mk(O_MGB, 1));
    t_base = 4'd6;
    run_row(mk(O_MGB, 6, 0, 0, 0, 0, 0));
    run_row(mk(O_MGB, 1));
    t_base = 4'd6;
    run_row(mk(O_MGB, 6, 1));
    run_row(mk(O_MGE, 3));
    run_row(mk(O_MY, 2));
    run_row(mk(O_SG, 6));
    sensor_sync = 1'b0; walk_request = 1'b0; prog_sync = 1'b0;
    #1 check("sy_before_reset", {O_SY, 1'b0});
    #1 Reset_Sync = 1'b1;
    #1 check("async_reset_mid_cycle", {O_MGB, 1'b0});
    @(negedge clk);
    Reset_Sync = 1'b0;
    run_row(mk(O_MGB, 6));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
